// File: rtl/reorder_commit_unit.sv
// Generic circular FIFO: head is first-word-fall-through, reads as zero when empty.
// Latency: a push is visible at the head on the cycle after its edge. Full/empty come from registered state.
// Backpressure: a push while full is dropped, even with a same-cycle pull. A pull while empty is ignored.
module rcu_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pull_vld,
    input  logic             upd_vld,
    input  logic             upd_bit,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] last_ptr;
    logic [PTR_W:0]   count_q;
    logic             push_ok;
    logic             pull_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign push_ok  = push_vld & ~full;
    assign pull_ok  = pull_vld & ~empty;
    assign last_ptr = wr_ptr_q - PTR_W'(1);
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

    // The youngest stored entry sits one slot behind the write pointer, so a
    // same-cycle push (which writes at wr_ptr_q) never collides with an update.
    always_ff @(posedge clk_i) begin
        if (upd_vld && !empty) begin
            mem_q[last_ptr][0] <= upd_bit;
        end
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pull_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_ok && !pull_ok) begin
                count_q <= count_q + (PTR_W+1)'(1);
            end else if (pull_ok && !push_ok) begin
                count_q <= count_q - (PTR_W+1)'(1);
            end
        end
    end
endmodule

// Reorder/commit tracker: retires micro-ops in trace order and emits instruction IDs in program order.
// Latency: a completion pulse at edge k allows retirement at edge k+1; the committed ID is visible after k+1.
// Backpressure: full_o refuses new micro-ops/IDs; a full committed-ID FIFO stalls only breakpoint heads.
module reorder_commit_unit #(
    parameter int   NUM_QUEUES = 4,
    parameter int   DEPTH      = 8,
    parameter logic BREAKPOINT = 1'b1,
    localparam int  ID_WIDTH   = $clog2(DEPTH),
    localparam int  SEL_WIDTH  = $clog2(NUM_QUEUES)
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    output logic                  full_o,
    input  logic                  trace_id_push_i,
    input  logic [ID_WIDTH-1:0]   trace_id_value_i,
    input  logic                  trace_push_i,
    input  logic [SEL_WIDTH-1:0]  trace_sel_i,
    input  logic                  trace_break_i,
    input  logic                  trace_update_i,
    input  logic [NUM_QUEUES-1:0] queues_status_push_i,
    input  logic                  commit_id_pull_i,
    output logic                  commit_id_valid_o,
    output logic [ID_WIDTH-1:0]   commit_id_value_o,
    output logic                  commit_id_full_o
);
    localparam int CNT_W = ID_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = DEPTH[CNT_W-1:0];

    logic [SEL_WIDTH:0]    tr_head;
    logic [SEL_WIDTH-1:0]  tr_head_sel;
    logic                  tr_head_brk;
    logic                  tr_empty;
    logic                  tr_full;
    logic [ID_WIDTH-1:0]   id_head;
    logic                  id_empty;
    logic                  id_full;
    logic [ID_WIDTH-1:0]   cm_head;
    logic                  cm_empty;
    logic                  cm_full;

    logic [CNT_W-1:0]      cnt_q [NUM_QUEUES];
    logic [CNT_W-1:0]      head_cnt;
    logic [NUM_QUEUES-1:0] cnt_inc;
    logic [NUM_QUEUES-1:0] cnt_dec;
    logic                  head_is_brk;
    logic                  retire;
    logic                  commit_push;
    logic                  tr_push;
    logic                  id_push;

    assign full_o      = tr_full | id_full;
    assign tr_push     = trace_push_i & ~full_o;
    assign id_push     = trace_id_push_i & ~full_o;
    assign tr_head_sel = tr_head[SEL_WIDTH:1];
    assign tr_head_brk = tr_head[0];
    assign head_is_brk = (tr_head_brk == BREAKPOINT);

    rcu_fifo #(.WIDTH(SEL_WIDTH + 1), .DEPTH(DEPTH)) u_trace_fifo (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .push_vld (tr_push),
        .push_dat ({trace_sel_i, trace_break_i}),
        .pull_vld (retire),
        .upd_vld  (trace_update_i),
        .upd_bit  (BREAKPOINT),
        .head_dat (tr_head),
        .empty    (tr_empty),
        .full     (tr_full)
    );

    rcu_fifo #(.WIDTH(ID_WIDTH), .DEPTH(DEPTH)) u_id_fifo (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .push_vld (id_push),
        .push_dat (trace_id_value_i),
        .pull_vld (commit_push),
        .upd_vld  (1'b0),
        .upd_bit  (1'b0),
        .head_dat (id_head),
        .empty    (id_empty),
        .full     (id_full)
    );

    rcu_fifo #(.WIDTH(ID_WIDTH), .DEPTH(DEPTH)) u_commit_fifo (
        .clk_i    (clk_i),
        .srst_i   (srst_i),
        .push_vld (commit_push),
        .push_dat (id_head),
        .pull_vld (commit_id_pull_i),
        .upd_vld  (1'b0),
        .upd_bit  (1'b0),
        .head_dat (cm_head),
        .empty    (cm_empty),
        .full     (cm_full)
    );

    // Retirement looks only at registered counters; a completion arriving this
    // cycle becomes usable on the next one.
    always_comb begin
        head_cnt = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (tr_head_sel == SEL_WIDTH'(q)) begin
                head_cnt = cnt_q[q];
            end
        end
        retire      = !tr_empty && (head_cnt != '0) &&
                      (!head_is_brk || (!id_empty && !cm_full));
        commit_push = retire && head_is_brk;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            cnt_inc[q] = queues_status_push_i[q];
            cnt_dec[q] = retire && (tr_head_sel == SEL_WIDTH'(q));
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                cnt_q[q] <= '0;
            end
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                if (cnt_inc[q] && !cnt_dec[q] && (cnt_q[q] != CNT_MAX)) begin
                    cnt_q[q] <= cnt_q[q] + CNT_W'(1);
                end else if (cnt_dec[q] && !cnt_inc[q]) begin
                    cnt_q[q] <= cnt_q[q] - CNT_W'(1);
                end
            end
        end
    end

    assign commit_id_valid_o = ~cm_empty;
    assign commit_id_value_o = cm_head;
    assign commit_id_full_o  = cm_full;
endmodule

// File: tb/tb_reorder_commit_unit.sv
module tb_reorder_commit_unit;
    localparam int NQ    = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       srst;
    logic       full;
    logic       trace_id_push;
    logic [2:0] trace_id_value;
    logic       trace_push;
    logic [1:0] trace_sel;
    logic       trace_break;
    logic       trace_update;
    logic [3:0] status;
    logic       commit_pull;
    logic       commit_valid;
    logic [2:0] commit_value;
    logic       commit_full;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int sel;
        int ready;
    } pend_t;
    pend_t pend[$];

    always #5 clk = ~clk;

    reorder_commit_unit #(.NUM_QUEUES(NQ), .DEPTH(DEPTH), .BREAKPOINT(1'b1)) dut (
        .clk_i                (clk),
        .srst_i               (srst),
        .full_o               (full),
        .trace_id_push_i      (trace_id_push),
        .trace_id_value_i     (trace_id_value),
        .trace_push_i         (trace_push),
        .trace_sel_i          (trace_sel),
        .trace_break_i        (trace_break),
        .trace_update_i       (trace_update),
        .queues_status_push_i (status),
        .commit_id_pull_i     (commit_pull),
        .commit_id_valid_o    (commit_valid),
        .commit_id_value_o    (commit_value),
        .commit_id_full_o     (commit_full)
    );

    task automatic clear_inputs();
        trace_id_push  = 1'b0;
        trace_id_value = '0;
        trace_push     = 1'b0;
        trace_sel      = '0;
        trace_break    = 1'b0;
        trace_update   = 1'b0;
        status         = '0;
        commit_pull    = 1'b0;
    endtask

    // One clock: inputs set before the call are sampled at the edge, then cleared.
    task automatic cycle();
        @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        srst = 1'b1;
        cycle();
        cycle();
        srst = 1'b0;
    endtask

    task automatic drive_uop(input logic [1:0] sel, input logic brk, input logic idp, input logic [2:0] id);
        trace_push     = 1'b1;
        trace_sel      = sel;
        trace_break    = brk;
        trace_id_push  = idp;
        trace_id_value = id;
        cycle();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", commit_valid); else n_pass++;
        n_checks++;
        if (commit_value !== 3'd0) $display("FAIL reset_value: got %0d want 0", commit_value); else n_pass++;
        n_checks++;
        if (commit_full !== 1'b0) $display("FAIL reset_cfull: got %b want 0", commit_full); else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        drive_uop(2'd2, 1'b1, 1'b1, 3'd3);
        status = 4'b0100;
        cycle();
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL single_early: valid %b want 0 after edge k", commit_valid); else n_pass++;
        cycle();
        n_checks++;
        if (commit_valid !== 1'b1) $display("FAIL single_valid: valid %b want 1 after edge k+1", commit_valid); else n_pass++;
        n_checks++;
        if (commit_value !== 3'd3) $display("FAIL single_value: got %0d want 3", commit_value); else n_pass++;
        commit_pull = 1'b1;
        cycle();
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL single_pull: valid %b want 0", commit_valid); else n_pass++;
    endtask

    task automatic test_out_of_order();
        do_reset();
        drive_uop(2'd0, 1'b0, 1'b0, 3'd0);
        drive_uop(2'd1, 1'b1, 1'b1, 3'd0);
        drive_uop(2'd2, 1'b1, 1'b1, 3'd1);
        status = 4'b0100;
        cycle();
        cycle();
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL ooo_q2_only: valid %b want 0", commit_valid); else n_pass++;
        status = 4'b0010;
        cycle();
        cycle();
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL ooo_q1_q2: valid %b want 0", commit_valid); else n_pass++;
        status = 4'b0001;
        cycle();
        cycle();
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL ooo_first_uop: valid %b want 0", commit_valid); else n_pass++;
        cycle();
        n_checks++;
        if (commit_valid !== 1'b1 || commit_value !== 3'd0)
            $display("FAIL ooo_first_commit: valid %b id %0d want valid 1 id 0", commit_valid, commit_value);
        else n_pass++;
        cycle();
        commit_pull = 1'b1;
        cycle();
        n_checks++;
        if (commit_valid !== 1'b1 || commit_value !== 3'd1)
            $display("FAIL ooo_second_commit: valid %b id %0d want valid 1 id 1", commit_valid, commit_value);
        else n_pass++;
        commit_pull = 1'b1;
        cycle();
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL ooo_drained: valid %b want 0", commit_valid); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive_uop(2'd0, 1'b0, 1'b0, 3'd0);
        n_checks++;
        if (full !== 1'b1) $display("FAIL full_set: got %b want 1", full); else n_pass++;
        drive_uop(2'd1, 1'b1, 1'b1, 3'd7);
        n_checks++;
        if (full !== 1'b1) $display("FAIL full_after_drop: got %b want 1", full); else n_pass++;
        status = 4'b0001;
        cycle();
        n_checks++;
        if (full !== 1'b1) $display("FAIL full_edge_k: got %b want 1", full); else n_pass++;
        cycle();
        n_checks++;
        if (full !== 1'b0) $display("FAIL full_release: got %b want 0", full); else n_pass++;
        for (int i = 0; i < DEPTH - 1; i++) begin
            status = 4'b0001;
            cycle();
        end
        drive_uop(2'd1, 1'b1, 1'b1, 3'd4);
        status = 4'b0010;
        cycle();
        wait_cycles(3);
        n_checks++;
        if (commit_valid !== 1'b1 || commit_value !== 3'd4)
            $display("FAIL full_dropped_id: valid %b id %0d want valid 1 id 4", commit_valid, commit_value);
        else n_pass++;
        commit_pull = 1'b1;
        cycle();
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL full_only_one: valid %b want 0", commit_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [2:0] id;
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            id = 3'((i + 2) % 8);
            status = 4'(1 << (i % NQ));
            drive_uop(2'(i % NQ), 1'b1, 1'b1, id);
        end
        wait_cycles(3);
        n_checks++;
        if (commit_full !== 1'b1) $display("FAIL bp_cfull: got %b want 1", commit_full); else n_pass++;
        n_checks++;
        if (full !== 1'b0) $display("FAIL bp_trace_free: got %b want 0", full); else n_pass++;
        status = 4'b0010;
        drive_uop(2'd1, 1'b1, 1'b1, 3'd2);
        wait_cycles(3);
        n_checks++;
        if (commit_full !== 1'b1) $display("FAIL bp_stall_full: got %b want 1", commit_full); else n_pass++;
        n_checks++;
        if (commit_value !== 3'd2) $display("FAIL bp_head: got %0d want 2", commit_value); else n_pass++;
        commit_pull = 1'b1;
        cycle();
        n_checks++;
        if (commit_full !== 1'b0) $display("FAIL bp_after_pull: got %b want 0", commit_full); else n_pass++;
        cycle();
        n_checks++;
        if (commit_full !== 1'b1) $display("FAIL bp_next_commit: got %b want 1", commit_full); else n_pass++;
        for (int i = 1; i <= DEPTH; i++) begin
            id = 3'((i + 2) % 8);
            n_checks++;
            if (commit_valid !== 1'b1 || commit_value !== id)
                $display("FAIL bp_drain%0d: valid %b id %0d want valid 1 id %0d", i, commit_valid, commit_value, id);
            else n_pass++;
            commit_pull = 1'b1;
            cycle();
        end
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL bp_empty: valid %b want 0", commit_valid); else n_pass++;
    endtask

    task automatic test_update();
        do_reset();
        drive_uop(2'd1, 1'b0, 1'b1, 3'd5);
        trace_update = 1'b1;
        cycle();
        status = 4'b0010;
        cycle();
        cycle();
        n_checks++;
        if (commit_valid !== 1'b1 || commit_value !== 3'd5)
            $display("FAIL update_commit: valid %b id %0d want valid 1 id 5", commit_valid, commit_value);
        else n_pass++;
        commit_pull = 1'b1;
        cycle();
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL update_pull: valid %b want 0", commit_valid); else n_pass++;
    endtask

    // Model: every pushed ID must come out exactly once, in push order.
    task automatic test_random();
        logic [2:0] exp_ids[$];
        int next_id;
        int ids_pushed;
        int uops_left;
        int idx;
        int sel;
        int lat;
        int n_ids;
        pend_t p;
        next_id    = 0;
        ids_pushed = 0;
        uops_left  = 0;
        n_ids      = 60;
        pend.delete();
        do_reset();
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (ids_pushed == n_ids && exp_ids.size() == 0) break;
            clear_inputs();
            if (commit_valid === 1'b1 && $urandom_range(0, 3) != 0) begin
                n_checks++;
                if (exp_ids.size() == 0)
                    $display("FAIL rand_commit: got id %0d with none outstanding", commit_value);
                else if (commit_value !== exp_ids[0])
                    $display("FAIL rand_commit: got id %0d want %0d", commit_value, exp_ids[0]);
                else n_pass++;
                if (exp_ids.size() > 0) void'(exp_ids.pop_front());
                commit_pull = 1'b1;
            end
            for (int q = 0; q < NQ; q++) begin
                idx = -1;
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].sel == q) begin
                        idx = i;
                        break;
                    end
                end
                if (idx >= 0 && pend[idx].ready <= cyc) begin
                    status[q] = 1'b1;
                    pend.delete(idx);
                end
            end
            if (full === 1'b0 && ids_pushed < n_ids && $urandom_range(0, 2) != 0) begin
                if (uops_left == 0) uops_left = $urandom_range(1, 3);
                sel = $urandom_range(0, NQ - 1);
                lat = $urandom_range(0, 19);
                p.sel   = sel;
                p.ready = cyc + lat;
                pend.push_back(p);
                trace_push = 1'b1;
                trace_sel  = 2'(sel);
                uops_left--;
                if (uops_left == 0) begin
                    trace_break    = 1'b1;
                    trace_id_push  = 1'b1;
                    trace_id_value = 3'(next_id);
                    exp_ids.push_back(3'(next_id));
                    next_id = (next_id + 1) % 8;
                    ids_pushed++;
                end
            end
            @(negedge clk);
        end
        clear_inputs();
        n_checks++;
        if (ids_pushed != n_ids || exp_ids.size() != 0)
            $display("FAIL rand_drain: pushed %0d of %0d, %0d IDs never committed", ids_pushed, n_ids, exp_ids.size());
        else n_pass++;
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int i = 0; i < DEPTH; i++) drive_uop(2'(i % NQ), 1'b1, 1'b1, 3'(i));
        n_checks++;
        if (full !== 1'b1) $display("FAIL mid_full: got %b want 1", full); else n_pass++;
        status = 4'b0011;
        cycle();
        cycle();
        cycle();
        n_checks++;
        if (commit_valid !== 1'b1 || commit_value !== 3'd0)
            $display("FAIL mid_commit: valid %b id %0d want valid 1 id 0", commit_valid, commit_value);
        else n_pass++;
        srst = 1'b1;
        cycle();
        srst = 1'b0;
        n_checks++;
        if (full !== 1'b0) $display("FAIL mid_rst_full: got %b want 0", full); else n_pass++;
        n_checks++;
        if (commit_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", commit_valid); else n_pass++;
        n_checks++;
        if (commit_value !== 3'd0) $display("FAIL mid_rst_value: got %0d want 0", commit_value); else n_pass++;
        n_checks++;
        if (commit_full !== 1'b0) $display("FAIL mid_rst_cfull: got %b want 0", commit_full); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            status = 4'b1111;
            cycle();
        end
        n_checks++;
        if (commit_valid !== 1'b0 || full !== 1'b0)
            $display("FAIL mid_no_partial: valid %b full %b want 0 0", commit_valid, full);
        else n_pass++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        srst = 1'b0;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_out_of_order();
        test_full();
        test_backpressure();
        test_update();
        test_random();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/reorder_commit_unit.md
Name: reorder_commit_unit

Overview:
- Reorder/commit tracker for out-of-order execution across NUM_QUEUES execution queues.
- Instructions (IDs) are issued in program order as 1..n micro-ops; each micro-op targets one queue.
- Each queue reports completions in its own issue order.
- The block retires micro-ops in trace order and pushes an instruction's ID into a committed-ID FIFO once its last micro-op (the breakpoint entry) has completed. IDs therefore leave in program order.

Parameters:
- NUM_QUEUES, 4, number of execution queues tracked.
- DEPTH, 8, entries in each internal FIFO (trace, ID, committed-ID); must be a power of two ≥2.
- BREAKPOINT, 1'b1, value of trace_break_i that marks the last micro-op of an instruction.
- Derived, not overridable: ID_WIDTH = clog2(DEPTH); SEL_WIDTH = clog2(NUM_QUEUES).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- srst_i  in  1  synchronous active-high reset.
- full_o  out  1  trace FIFO full OR ID FIFO full; new micro-ops/IDs are refused.
- trace_id_push_i  in  1  push trace_id_value_i into the ID FIFO.
- trace_id_value_i  in  ID_WIDTH  instruction ID.
- trace_push_i  in  1  push one micro-op entry {trace_sel_i, trace_break_i} into the trace FIFO.
- trace_sel_i  in  SEL_WIDTH  target queue of the micro-op.
- trace_break_i  in  1  equals BREAKPOINT on the instruction's last micro-op.
- trace_update_i  in  1  force the youngest stored trace entry to breakpoint.
- queues_status_push_i  in  NUM_QUEUES  one-cycle pulse per queue: that queue completed its oldest outstanding micro-op.
- commit_id_pull_i  in  1  pop the committed-ID FIFO head.
- commit_id_valid_o  out  1  committed-ID FIFO not empty.
- commit_id_value_o  out  ID_WIDTH  committed-ID FIFO head, first-word-fall-through.
- commit_id_full_o  out  1  committed-ID FIFO full.

Behaviour:
- Reset (srst_i=1 at a rising edge):
  - All FIFOs empty; completion counters cleared.
  - full_o=0, commit_id_valid_o=0, commit_id_value_o=0, commit_id_full_o=0.
  - Reset mid-operation discards all in-flight state with no partial commit.
- FIFOs: circular read/write pointers plus an occupancy count. Full is based on the registered state.
  - Push while full: dropped, even if a pull happens the same cycle.
  - Pull while empty: ignored.
  - Pull and push in the same cycle on a non-full FIFO: both occur, occupancy unchanged.
  - Pointers wrap modulo DEPTH.
- Trace FIFO entries hold {sel, brk}. The bench pushes trace_id_push_i on the same cycle as the breakpoint micro-op, so ID FIFO order matches breakpoint order.
- trace_update_i=1 with the trace FIFO non-empty: brk of the youngest stored entry is set to BREAKPOINT.
  - An entry pushed in the same cycle is not affected.
  - trace_update_i is ignored when the trace FIFO is empty.
- Completion counters, one per queue, width clog2(DEPTH)+1:
  - +1 on queues_status_push_i[q].
  - -1 when the trace-FIFO head with sel==q retires.
  - Both in the same cycle: value unchanged.
  - Completions in excess of outstanding micro-ops are illegal stimulus; the counter saturates at DEPTH.
- Retire rule, evaluated every cycle on registered state: the head retires (trace FIFO pop) when
  - the trace FIFO is non-empty, and
  - counter[head.sel]>0, and
  - if head.brk==BREAKPOINT: the ID FIFO is non-empty and the committed-ID FIFO is not full.
- On retiring a breakpoint head: pop the ID FIFO and push its head value into the committed-ID FIFO in the same edge.
- Throughput and latency:
  - At most one micro-op retires per cycle.
  - A completion pulse sampled at edge k allows retirement at edge k+1; commit_id_valid_o rises after edge k+1.
  - The same-cycle counter increment is not bypassed.
- Backpressure: committed-ID FIFO full stalls only breakpoint heads; commit_id_full_o mirrors it.
- Commit output: commit_id_value_o shows the head combinationally. commit_id_pull_i with valid pops it; the next entry appears after the edge.

Test Plan:
- Reset, then 1 ID=3 with 1 micro-op sel=2 brk=1; pulse queues_status_push_i=4'b0100 at edge k -> commit_id_valid_o=1 after edge k+1 with value 3; pull -> valid=0.
- Out-of-order completion: ID0 {sel0,brk=0},{sel1,brk=1}; ID1 {sel2,brk=1}. Complete q2, then q1, then q0 -> commits appear as 0 then 1, never 1 first.
- Fill to 8 trace entries with no completions -> full_o=1; a 9th push is dropped. One completion+retire -> full_o=0 one cycle later.
- Do not pull while completing 8 single-micro-op IDs -> commit_id_full_o=1, further breakpoint heads stall. One pull -> next ID commits the following cycle.
- Push {sel1,brk=0} plus ID 5, assert trace_update_i, complete q1 -> ID 5 commits.
- Random: 4 queues, 1-3 micro-ops per ID, random latency 0-19 cycles, IDs incrementing mod 8 -> commit sequence equals the push sequence of IDs exactly; assert srst_i mid-run -> all outputs 0 next cycle.
